// File: rtl/rs232_cmd_ctrl_if.sv
// rtl/rs232_cmd_ctrl_if.sv - UART byte strobes and register bus bundle for the command controller
interface rs232_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_trg;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rx_data, rx_done, tx_busy, reg_rdata,
    output tx_data, tx_trg, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_err, overrun
  );

  modport slave (
    output rx_data, rx_done, tx_busy, reg_rdata,
    input  tx_data, tx_trg, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_err, overrun
  );
endinterface

// File: rtl/rs232_cmd_ctrl.sv
// rtl/rs232_cmd_ctrl.sv - 3-byte FLOW/ADDR/DATA UART command engine driving the register bus
module rs232_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic               clk_50mhz_i,
  input  logic               rst_ni,
  rs232_cmd_ctrl_if.master   bus_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_EXEC, S_RD_WAIT, S_SEND, S_SEND_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       txd_q, txd_d;
  logic             skip_q, skip_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             timeout;
  logic             tx_trg, reg_we, reg_re;

  assign timeout = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_50mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      skip_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      skip_q  <= skip_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    skip_d  = skip_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    tx_trg  = 1'b0;
    reg_we  = 1'b0;
    reg_re  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus_if.rx_done) begin
          rd_d    = bus_if.rx_data[0];
          cnt_d   = '0;
          state_d = S_GET_ADDR;
        end
      end
      // A byte on the very cycle the timeout expires is still accepted.
      S_GET_ADDR, S_GET_DATA: begin
        if (bus_if.rx_done) begin
          cnt_d = '0;
          if (state_q == S_GET_ADDR) begin
            addr_d  = bus_if.rx_data;
            state_d = S_GET_DATA;
          end else begin
            if (!rd_q) wdata_d = bus_if.rx_data;
            state_d = S_EXEC;
          end
        end else if (timeout) begin
          cnt_d   = '0;
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (rd_q) begin
          reg_re  = 1'b1;
          state_d = S_RD_WAIT;
        end else begin
          reg_we  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        txd_d   = bus_if.reg_rdata;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!bus_if.tx_busy) begin
          tx_trg  = 1'b1;
          skip_d  = 1'b1;
          state_d = S_SEND_WAIT;
        end
      end
      // The UART raises busy one cycle after the trigger, so ignore busy for that cycle.
      S_SEND_WAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (!bus_if.tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus_if.rx_done && (state_q == S_EXEC || state_q == S_RD_WAIT ||
                           state_q == S_SEND || state_q == S_SEND_WAIT)) begin
      ovr_d = 1'b1;
    end
  end

  assign bus_if.tx_data   = txd_q;
  assign bus_if.tx_trg    = tx_trg;
  assign bus_if.reg_addr  = addr_q;
  assign bus_if.reg_wdata = wdata_q;
  assign bus_if.reg_we    = reg_we;
  assign bus_if.reg_re    = reg_re;
  assign bus_if.busy      = (state_q != S_IDLE);
  assign bus_if.frame_err = ferr_q;
  assign bus_if.overrun   = ovr_q;

endmodule

// File: tb/tb_rs232_cmd_ctrl.sv
// tb/tb_rs232_cmd_ctrl.sv - directed self-checking bench for rs232_cmd_ctrl
module tb_rs232_cmd_ctrl;
  localparam int unsigned T = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_trg = 0, n_we = 0, n_re = 0, n_ferr = 0, n_ovr = 0, n_both = 0;
  int   base_trg, base_we, base_re, base_ferr, base_ovr;

  rs232_cmd_ctrl_if bus ();

  rs232_cmd_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(6)) dut (
    .clk_50mhz_i (clk),
    .rst_ni      (rst_n),
    .bus_if      (bus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tx_trg)    n_trg++;
    if (bus.reg_we)    n_we++;
    if (bus.reg_re)    n_re++;
    if (bus.frame_err) n_ferr++;
    if (bus.overrun)   n_ovr++;
    if (bus.reg_we && bus.reg_re) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic snap();
    base_trg = n_trg; base_we = n_we; base_re = n_re; base_ferr = n_ferr; base_ovr = n_ovr;
  endtask

  initial begin
    bus.rx_data = 8'h00; bus.rx_done = 1'b0; bus.tx_busy = 1'b0; bus.reg_rdata = 8'h00;

    #12;
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_outs",  {bus.tx_data, bus.reg_addr, bus.reg_wdata, 8'(0)}, 32'd0);
    check("rst_strb",  {27'd0, bus.tx_trg, bus.reg_we, bus.reg_re, bus.frame_err, bus.overrun}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Write frame 00,7B,02
    snap();
    send_byte(8'h00); send_byte(8'h7B); send_byte(8'h02);
    check("wr_we",    32'(bus.reg_we), 32'd1);
    check("wr_re",    32'(bus.reg_re), 32'd0);
    check("wr_addr",  32'(bus.reg_addr), 32'h7B);
    check("wr_wdata", 32'(bus.reg_wdata), 32'h02);
    @(posedge clk); #1;
    check("wr_idle",  32'(bus.busy), 32'd0);
    check("wr_hold",  32'(bus.reg_addr), 32'h7B);
    check("wr_nwe",   32'(n_we - base_we), 32'd1);
    check("wr_ntrg",  32'(n_trg - base_trg), 32'd0);

    // Read frame 01,EA,FF with REG_RDATA=5A
    snap();
    bus.reg_rdata = 8'h5A;
    send_byte(8'h01); send_byte(8'hEA); send_byte(8'hFF);
    check("rd_re",    32'(bus.reg_re), 32'd1);
    check("rd_addr",  32'(bus.reg_addr), 32'hEA);
    check("rd_wkeep", 32'(bus.reg_wdata), 32'h02);
    @(posedge clk); #1;
    check("rd_notrg1", 32'(bus.tx_trg), 32'd0);
    @(posedge clk); #1;
    check("rd_trg",   32'(bus.tx_trg), 32'd1);
    check("rd_txd",   32'(bus.tx_data), 32'h5A);
    @(posedge clk); #1 bus.tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rd_sendwait", 32'(bus.busy), 32'd1);
    end
    bus.tx_busy = 1'b0;
    @(posedge clk); #1;
    check("rd_idle",  32'(bus.busy), 32'd0);
    check("rd_ntrg",  32'(n_trg - base_trg), 32'd1);
    check("rd_nwe",   32'(n_we - base_we), 32'd0);
    check("rd_nre",   32'(n_re - base_re), 32'd1);

    // Read with TX_BUSY held for 1000 cycles
    snap();
    bus.reg_rdata = 8'hC3;
    bus.tx_busy = 1'b1;
    send_byte(8'h81); send_byte(8'h44); send_byte(8'h00);
    repeat (1000) @(posedge clk);
    #1;
    check("bsy_held",  32'(n_trg - base_trg), 32'd0);
    check("bsy_state", 32'(bus.busy), 32'd1);
    bus.tx_busy = 1'b0;
    #1;
    check("bsy_trg",   32'(bus.tx_trg), 32'd1);
    check("bsy_txd",   32'(bus.tx_data), 32'hC3);
    @(posedge clk); #1 bus.tx_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.tx_busy = 1'b0;
    @(posedge clk); #1;
    check("bsy_idle",  32'(bus.busy), 32'd0);
    check("bsy_ntrg",  32'(n_trg - base_trg), 32'd1);

    // Timeout after 00,7B; error pulse lands exactly on the T-th idle cycle
    snap();
    send_byte(8'h00); send_byte(8'h7B);
    repeat (T - 1) @(posedge clk);
    #1;
    check("to_early",  32'(bus.frame_err), 32'd0);
    check("to_busy",   32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("to_ferr",   32'(bus.frame_err), 32'd1);
    check("to_idle",   32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("to_pulse",  32'(n_ferr - base_ferr), 32'd1);
    check("to_nwe",    32'(n_we - base_we), 32'd0);

    // Next frame 00,10,33 with the ADDR byte arriving on the expiry cycle
    snap();
    send_byte(8'h00);
    repeat (T - 1) @(posedge clk);
    #1;
    bus.rx_data = 8'h10; bus.rx_done = 1'b1;
    @(posedge clk); #1 bus.rx_done = 1'b0;
    check("edge_noerr", 32'(bus.frame_err), 32'd0);
    check("edge_busy",  32'(bus.busy), 32'd1);
    send_byte(8'h33);
    check("nx_we",     32'(bus.reg_we), 32'd1);
    check("nx_addr",   32'(bus.reg_addr), 32'h10);
    check("nx_wdata",  32'(bus.reg_wdata), 32'h33);
    @(posedge clk); #1;
    check("nx_nferr",  32'(n_ferr - base_ferr), 32'd0);

    // Extra RX byte during SEND_WAIT
    snap();
    bus.reg_rdata = 8'h3C;
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ov_trg",    32'(bus.tx_trg), 32'd1);
    @(posedge clk); #1;
    bus.tx_busy = 1'b1;
    bus.rx_data = 8'h99; bus.rx_done = 1'b1;
    @(posedge clk); #1 bus.rx_done = 1'b0;
    check("ov_pulse",  32'(bus.overrun), 32'd1);
    check("ov_txd",    32'(bus.tx_data), 32'h3C);
    check("ov_busy",   32'(bus.busy), 32'd1);
    bus.tx_busy = 1'b0;
    @(posedge clk); #1;
    check("ov_idle",   32'(bus.busy), 32'd0);
    check("ov_cnt",    32'(n_ovr - base_ovr), 32'd1);
    check("ov_addr",   32'(bus.reg_addr), 32'h20);

    // Reset after the second byte, then a normal write frame
    snap();
    send_byte(8'h00); send_byte(8'hAB);
    #1 rst_n = 1'b0;
    #2;
    check("mr_busy",   32'(bus.busy), 32'd0);
    check("mr_outs",   {bus.tx_data, bus.reg_addr, bus.reg_wdata, 8'(0)}, 32'd0);
    check("mr_strb",   {27'd0, bus.tx_trg, bus.reg_we, bus.reg_re, bus.frame_err, bus.overrun}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
    check("mr_we",     32'(bus.reg_we), 32'd1);
    check("mr_addr",   32'(bus.reg_addr), 32'h55);
    check("mr_wdata",  32'(bus.reg_wdata), 32'h66);
    @(posedge clk); #1;
    check("mr_nwe",    32'(n_we - base_we), 32'd1);
    check("excl",      32'(n_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
